// File: rtl/eth_intr_pkg.sv
// Shared definitions for the Ethernet MAC interrupt controller:
// register map, source bit order, coalescer FSM states and INT_COAL/INT_STAT fields.
package eth_intr_pkg;

    localparam logic [1:0] INT_SOURCE_ADR = 2'd0;
    localparam logic [1:0] INT_MASK_ADR   = 2'd1;
    localparam logic [1:0] INT_COAL_ADR   = 2'd2;
    localparam logic [1:0] INT_STAT_ADR   = 2'd3;

    localparam int SRC_TXB  = 0;
    localparam int SRC_TXE  = 1;
    localparam int SRC_RXB  = 2;
    localparam int SRC_RXE  = 3;
    localparam int SRC_BUSY = 4;
    localparam int SRC_TXC  = 5;
    localparam int SRC_RXC  = 6;

    localparam int COAL_CTH_LSB  = 0;
    localparam int COAL_TMO_LSB  = 8;
    localparam int STAT_INTR_BIT = 8;
    localparam int STAT_TRUN_BIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_ASSERT
    } intr_state_e;

    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/eth_intr_coal.sv
// Count/timeout interrupt coalescer: turns enabled-event and pending-enabled
// terms into the level interrupt request.
module eth_intr_coal
    import eth_intr_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             evt_en,
    input  logic             pend_en,
    input  logic [CNT_W-1:0] cth,
    input  logic [TMO_W-1:0] tmo,
    output logic             intr,
    output logic [CNT_W-1:0] count,
    output logic             tmr_run
);

    intr_state_e      state, state_nxt;
    logic [CNT_W-1:0] count_nxt, count_inc;
    logic [TMO_W-1:0] timer, timer_nxt;

    assign count_inc = (&count) ? count : count + CNT_W'(1);
    assign tmr_run   = (state == ST_ACCUM) && (timer != '0);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        timer_nxt = timer;
        unique case (state)
            ST_IDLE: begin
                if (evt_en) begin
                    if (cth <= CNT_W'(1)) begin
                        state_nxt = ST_ASSERT;
                    end else begin
                        state_nxt = ST_ACCUM;
                        count_nxt = CNT_W'(1);
                        timer_nxt = tmo;
                    end
                end else if (pend_en) begin
                    state_nxt = ST_ASSERT;
                end
            end
            ST_ACCUM: begin
                // timer == 1 here means it reaches 0 on this edge
                if (timer != '0) timer_nxt = timer - TMO_W'(1);
                if (evt_en) count_nxt = count_inc;
                if ((evt_en && (count_inc >= cth)) || (timer == TMO_W'(1))) begin
                    state_nxt = ST_ASSERT;
                end else if (!pend_en && !evt_en) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                    timer_nxt = '0;
                end
            end
            ST_ASSERT: begin
                if (!pend_en) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = '0;
                timer_nxt = '0;
            end
        endcase
    end

    // Rises with the ASSERT entry edge, falls one cycle after ASSERT is left.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state <= ST_IDLE;
            count <= '0;
            timer <= '0;
            intr  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            timer <= timer_nxt;
            intr  <= (state == ST_ASSERT) || (state_nxt == ST_ASSERT);
        end
    end

endmodule

// File: rtl/eth_intr_ctrl.sv
// Ethernet MAC interrupt controller: sticky source register, mask, coalescing
// config and status behind a single-cycle-ack Wishbone slave.
module eth_intr_ctrl
    import eth_intr_pkg::*;
#(
    parameter int NUM_SRC = 7,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic [NUM_SRC-1:0] evt_i,
    input  logic [1:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_intr
);

    logic [NUM_SRC-1:0] int_src, int_mask, src_clr, dat_src, wm_src;
    logic [CNT_W-1:0]   cth_q, count;
    logic [TMO_W-1:0]   tmo_q;
    logic [31:0]        wmask, coal_rd, coal_wr, stat_rd, rd_mux;
    logic               bus_hit, wr, tmr_run;
    logic               unused_dat;

    assign bus_hit    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr         = bus_hit & wb_we_i;
    assign wmask      = sel_to_mask(wb_sel_i);
    assign dat_src    = wb_dat_i[NUM_SRC-1:0];
    assign wm_src     = wmask[NUM_SRC-1:0];
    assign src_clr    = (wr && wb_adr_i == INT_SOURCE_ADR) ? (dat_src & wm_src) : '0;
    assign coal_wr    = (coal_rd & ~wmask) | (wb_dat_i & wmask);
    assign unused_dat = ^{wb_dat_i, coal_wr};

    always_comb begin
        coal_rd = '0;
        coal_rd[COAL_CTH_LSB +: CNT_W] = cth_q;
        coal_rd[COAL_TMO_LSB +: TMO_W] = tmo_q;
        stat_rd = '0;
        stat_rd[7:0]          = 8'(count);
        stat_rd[STAT_INTR_BIT] = wb_intr;
        stat_rd[STAT_TRUN_BIT] = tmr_run;
        rd_mux = '0;
        unique case (wb_adr_i)
            INT_SOURCE_ADR: rd_mux[NUM_SRC-1:0] = int_src;
            INT_MASK_ADR:   rd_mux[NUM_SRC-1:0] = int_mask;
            INT_COAL_ADR:   rd_mux = coal_rd;
            default:        rd_mux = stat_rd;
        endcase
    end

    // A new event overrides a W1C to the same bit on the same edge.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            int_src  <= '0;
            int_mask <= '0;
            cth_q    <= '0;
            tmo_q    <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            int_src  <= (int_src & ~src_clr) | evt_i;
            wb_ack_o <= bus_hit;
            wb_dat_o <= bus_hit ? rd_mux : '0;
            if (wr && wb_adr_i == INT_MASK_ADR)
                int_mask <= (int_mask & ~wm_src) | (dat_src & wm_src);
            if (wr && wb_adr_i == INT_COAL_ADR) begin
                cth_q <= coal_wr[COAL_CTH_LSB +: CNT_W];
                tmo_q <= coal_wr[COAL_TMO_LSB +: TMO_W];
            end
        end
    end

    eth_intr_coal #(.CNT_W(CNT_W), .TMO_W(TMO_W)) u_coal (
        .wb_clk  (wb_clk),
        .wb_rst  (wb_rst),
        .evt_en  (|(evt_i & int_mask)),
        .pend_en (|(int_src & int_mask)),
        .cth     (cth_q),
        .tmo     (tmo_q),
        .intr    (wb_intr),
        .count   (count),
        .tmr_run (tmr_run)
    );

endmodule

// File: tb/tb_eth_intr_ctrl.sv
// Scoreboard bench for eth_intr_ctrl: bus reads and timed wb_intr levels are
// queued by the stimulus and checked by an independent monitor.
module tb_eth_intr_ctrl;
    import eth_intr_pkg::*;

    localparam int NUM_SRC = 7;
    localparam int CNT_W   = 8;
    localparam int TMO_W   = 16;

    logic               wb_clk = 1'b0;
    logic               wb_rst = 1'b0;
    logic [NUM_SRC-1:0] evt_i = '0;
    logic [1:0]         wb_adr_i = '0;
    logic [31:0]        wb_dat_i = '0;
    logic [3:0]         wb_sel_i = '0;
    logic               wb_we_i = 1'b0;
    logic               wb_stb_i = 1'b0;
    logic               wb_cyc_i = 1'b0;
    logic [31:0]        wb_dat_o;
    logic               wb_ack_o;
    logic               wb_intr;

    eth_intr_ctrl #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .evt_i(evt_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_intr(wb_intr)
    );

    always #5 wb_clk = ~wb_clk;

    int cyc = 0;
    always @(posedge wb_clk) cyc <= cyc + 1;

    typedef struct { logic is_rd; logic [31:0] exp; string name; } bus_exp_t;
    typedef struct { int at; logic exp; string name; } lvl_exp_t;

    bus_exp_t bq[$];
    lvl_exp_t lq[$];
    bus_exp_t mb;
    lvl_exp_t ml;
    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge wb_clk) begin
        if (wb_ack_o) begin
            if (bq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_ack: ack=1 at cycle %0d, required no ack", cyc);
            end else begin
                mb = bq.pop_front();
                if (mb.is_rd) begin
                    n_tests++;
                    if (wb_dat_o !== mb.exp) begin
                        n_fail++;
                        $display("FAIL %s: dat_o=%h required %h", mb.name, wb_dat_o, mb.exp);
                    end
                end
            end
        end
        while (lq.size() > 0 && lq[0].at <= cyc) begin
            ml = lq.pop_front();
            n_tests++;
            if (ml.at < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", ml.name, ml.at, cyc);
            end else if (wb_intr !== ml.exp) begin
                n_fail++;
                $display("FAIL %s: wb_intr=%b required %b at cycle %0d", ml.name, wb_intr, ml.exp, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk); #1;
    endtask

    task automatic exp_intr(input int at, input logic v, input string name);
        lvl_exp_t e;
        e.at = at; e.exp = v; e.name = name;
        lq.push_back(e);
    endtask

    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string name,
                       input logic [NUM_SRC-1:0] evt);
        bus_exp_t e;
        e.is_rd = !we; e.exp = exp; e.name = name;
        bq.push_back(e);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; evt_i = evt;
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; evt_i = '0;
        tick();
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
        bus(1'b1, adr, dat, 4'hF, 32'h0, "wr", '0);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'h0, 4'hF, exp, name, '0);
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] v);
        evt_i = v; tick(); evt_i = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, c0;
        repeat (3) tick();
        wb_rst = 1'b1;
        exp_intr(cyc, 1'b0, "intr_after_reset");
        rd(INT_SOURCE_ADR, 32'h0, "rst_source");
        rd(INT_MASK_ADR,   32'h0, "rst_mask");
        rd(INT_COAL_ADR,   32'h0, "rst_coal");
        rd(INT_STAT_ADR,   32'h0, "rst_stat");

        // Back-to-back: stb held 4 cycles yields two acks.
        wr(INT_MASK_ADR, 32'h1);
        bus_b2b(32'h1);

        // Immediate path.
        k = cyc;
        exp_intr(k, 1'b0, "imm_before");
        exp_intr(k + 1, 1'b1, "imm_rise");
        pulse(7'h01);
        rd(INT_SOURCE_ADR, 32'h1, "imm_source");
        c0 = cyc;
        exp_intr(c0 + 2, 1'b1, "imm_hold_after_ack");
        exp_intr(c0 + 3, 1'b0, "imm_fall");
        wr(INT_SOURCE_ADR, 32'h1);
        tick();

        // Masked event, then unmask.
        wr(INT_MASK_ADR, 32'h0);
        k = cyc;
        exp_intr(k + 1, 1'b0, "masked_no_intr");
        exp_intr(k + 3, 1'b0, "masked_no_intr2");
        pulse(7'h04);
        rd(INT_SOURCE_ADR, 32'h4, "masked_source");
        c0 = cyc;
        exp_intr(c0 + 1, 1'b0, "unmask_before");
        exp_intr(c0 + 2, 1'b1, "unmask_rise");
        wr(INT_MASK_ADR, 32'h4);

        // W1C with byte 0 disabled must not clear bit 2.
        bus(1'b1, INT_SOURCE_ADR, 32'h4, 4'b1110, 32'h0, "wr", '0);
        rd(INT_SOURCE_ADR, 32'h4, "sel_masked_w1c");

        // Set/clear race on bit 2.
        c0 = cyc;
        exp_intr(c0 + 2, 1'b1, "race_hold");
        exp_intr(c0 + 3, 1'b1, "race_hold2");
        bus(1'b1, INT_SOURCE_ADR, 32'h4, 4'hF, 32'h0, "wr", 7'h04);
        tick();
        rd(INT_SOURCE_ADR, 32'h4, "race_source");
        c0 = cyc;
        exp_intr(c0 + 3, 1'b0, "race_clear_fall");
        wr(INT_SOURCE_ADR, 32'h4);
        tick();

        // Count coalescing: CTH=4, TMO=0.
        wr(INT_MASK_ADR, 32'h1);
        wr(INT_COAL_ADR, 32'h0000_0004);
        k = cyc;
        exp_intr(k + 9, 1'b0, "cnt_before_4th");
        exp_intr(k + 10, 1'b1, "cnt_rise");
        for (int i = 0; i < 4; i++) begin
            pulse(7'h01);
            if (i < 3) begin tick(); tick(); end
        end
        rd(INT_STAT_ADR, 32'h104, "cnt_stat");
        wr(INT_SOURCE_ADR, 32'h1);
        tick();
        rd(INT_STAT_ADR, 32'h0, "cnt_stat_cleared");

        // Timeout: CTH=8, TMO=20.
        wr(INT_COAL_ADR, 32'h0000_1408);
        rd(INT_COAL_ADR, 32'h0000_1408, "coal_readback");
        k = cyc;
        exp_intr(k + 20, 1'b0, "tmo_before");
        exp_intr(k + 21, 1'b1, "tmo_rise");
        pulse(7'h01);
        rd(INT_STAT_ADR, 32'h201, "tmo_stat_running");
        while (cyc < k + 22) tick();
        rd(INT_STAT_ADR, 32'h101, "tmo_stat_asserted");
        wr(INT_SOURCE_ADR, 32'h1);
        tick();

        // Reset in ACCUM with count 3, mid bus cycle.
        wr(INT_MASK_ADR, 32'h7F);
        wr(INT_COAL_ADR, 32'h0000_0008);
        for (int i = 0; i < 3; i++) begin pulse(7'h03); tick(); end
        rd(INT_STAT_ADR, 32'h003, "accum_stat_cnt3");
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = INT_MASK_ADR; wb_dat_i = 32'h7F; wb_sel_i = 4'hF;
        wb_rst = 1'b0;
        tick();
        chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("rst_dat_o", wb_dat_o, 32'h0);
        chk("rst_intr", {31'h0, wb_intr}, 32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_rst = 1'b1;
        exp_intr(cyc, 1'b0, "intr_after_mid_reset");
        rd(INT_SOURCE_ADR, 32'h0, "mid_rst_source");
        rd(INT_MASK_ADR,   32'h0, "mid_rst_mask");
        rd(INT_COAL_ADR,   32'h0, "mid_rst_coal");
        rd(INT_STAT_ADR,   32'h0, "mid_rst_stat");

        repeat (3) tick();
        if (bq.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL missing_ack: %0d bus responses outstanding, required 0", bq.size());
        end
        if (lq.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL unchecked_levels: %0d level checks outstanding, required 0", lq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic bus_b2b(input logic [31:0] exp);
        bus_exp_t e;
        e.is_rd = 1'b1; e.exp = exp; e.name = "b2b_read";
        bq.push_back(e);
        bq.push_back(e);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = INT_MASK_ADR; wb_sel_i = 4'hF;
        repeat (4) tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
    endtask

endmodule
